systolic_pingpong_buffer: RTL and testbench

//  Multi-bank ping-pong row buffer between the systolic array output and the downstream stage.
//  The array writes rows of N_SIZE lanes into one bank while the consumer drains a previously filled bank.

---
 rtl/systolic_pingpong_buffer_if.sv | 26 ++
 rtl/systolic_pingpong_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_systolic_pingpong_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pingpong_buffer_if.sv
// Row-stream bundle for systolic_pingpong_buffer: the write side carries rows in and the read side carries rows out.
// The buffer connects through the slave modport. The producer and the consumer connect through master.
interface systolic_pingpong_buffer_if #(
  parameter int W  = 1024,
  parameter int BW = 1
);
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data;
  logic          wr_last;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic          rd_last;
  logic [BW-1:0] rd_bank;

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last, rd_bank
  );

  modport master (
    output wr_valid, wr_data, wr_last, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last, rd_bank
  );
endinterface

// File: rtl/systolic_pingpong_buffer.sv
// Multi-bank round-robin row buffer between the systolic array and the downstream stage.
// Define SYSBUF_STATUS_EN to add the full_banks and err_drop status outputs.
module systolic_pingpong_buffer #(
  parameter int DATAWIDTH_output = 32,
  parameter int N_SIZE           = 32,
  parameter int DEPTH            = 543,
  parameter int ADDR_WIDTH       = 10,
  parameter int NUM_BANKS        = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  systolic_pingpong_buffer_if.slave bus
`ifdef SYSBUF_STATUS_EN
  ,
  output logic [$clog2(NUM_BANKS+1)-1:0] full_banks,
  output logic                           err_drop
`endif
);

  localparam int W  = DATAWIDTH_output * N_SIZE;
  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_e;

  bank_state_e           state_q [NUM_BANKS];
  bank_state_e           state_d [NUM_BANKS];
  logic [CW-1:0]         cnt_q   [NUM_BANKS];
  logic [CW-1:0]         cnt_d   [NUM_BANKS];
  logic [BW-1:0]         wb_q, wb_d, rb_q, rb_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [CW-1:0]         raddr_q, raddr_d;
  logic                  p1_valid_q, p1_valid_d, p1_last_q, p1_last_d;
  logic [BW-1:0]         p1_bank_q, p1_bank_d;
  logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [W-1:0]          rd_data_q, rd_data_d;
  logic [BW-1:0]         rd_bank_q, rd_bank_d;

  logic [W-1:0]          mem [NUM_BANKS][DEPTH];
  logic [W-1:0]          mem_rdata_q;

  logic wr_ready, wr_beat, wr_close, out_load, rd_issue, rd_done;

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == BW'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  // The row in flight from memory (p1) plus the output register form a two-slot pipe.
  // Together they keep throughput at 1 row/clk while rd_ready stalls.
  always_comb begin
    wr_ready = ((state_q[wb_q] == B_EMPTY) || (state_q[wb_q] == B_FILLING)) && !flush;
    wr_beat  = bus.wr_valid && wr_ready;
    wr_close = wr_beat && (bus.wr_last || (waddr_q == ADDR_WIDTH'(DEPTH - 1)));
    out_load = !rd_valid_q || bus.rd_ready;
    rd_issue = !flush
            && ((state_q[rb_q] == B_FULL) || (state_q[rb_q] == B_DRAINING))
            && (raddr_q < cnt_q[rb_q])
            && (!p1_valid_q || out_load);
    rd_done  = rd_valid_q && bus.rd_ready && rd_last_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    p1_valid_d = p1_valid_q;
    p1_last_d  = p1_last_q;
    p1_bank_d  = p1_bank_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    rd_bank_d  = rd_bank_q;

    if (flush) begin
      for (int i = 0; i < NUM_BANKS; i++) state_d[i] = B_EMPTY;
      wb_d       = '0;
      rb_d       = '0;
      waddr_d    = '0;
      raddr_d    = '0;
      p1_valid_d = 1'b0;
      p1_last_d  = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_bank_d  = '0;
    end else begin
      if (wr_beat) begin
        if (wr_close) begin
          cnt_d[wb_q]   = CW'(waddr_q) + 1'b1;
          state_d[wb_q] = B_FULL;
          waddr_d       = '0;
          wb_d          = next_bank(wb_q);
        end else begin
          state_d[wb_q] = B_FILLING;
          waddr_d       = waddr_q + 1'b1;
        end
      end

      if (rd_issue) begin
        state_d[rb_q] = B_DRAINING;
        raddr_d       = raddr_q + 1'b1;
        p1_last_d     = ((raddr_q + 1'b1) == cnt_q[rb_q]);
        p1_bank_d     = rb_q;
        p1_valid_d    = 1'b1;
      end else if (out_load) begin
        p1_valid_d    = 1'b0;
      end

      if (out_load) begin
        rd_valid_d = p1_valid_q;
        rd_last_d  = p1_valid_q && p1_last_q;
        if (p1_valid_q) begin
          rd_data_d = mem_rdata_q;
          rd_bank_d = p1_bank_q;
        end
      end

      // A drained bank and a closing bank are never the same bank, so these updates cannot collide.
      if (rd_done) begin
        state_d[rb_q] = B_EMPTY;
        rb_d          = next_bank(rb_q);
        raddr_d       = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= B_EMPTY;
        cnt_q[i]   <= '0;
      end
      wb_q       <= '0;
      rb_q       <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      p1_valid_q <= 1'b0;
      p1_last_q  <= 1'b0;
      p1_bank_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_bank_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      p1_valid_q <= p1_valid_d;
      p1_last_q  <= p1_last_d;
      p1_bank_q  <= p1_bank_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // Row storage is never reset. The read port has an enable, so a stalled row stays in mem_rdata_q.
  always_ff @(posedge clk) begin
    if (wr_beat) mem[wb_q][waddr_q] <= bus.wr_data;
    if (rd_issue) mem_rdata_q <= mem[rb_q][raddr_q[ADDR_WIDTH-1:0]];
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_bank  = rd_bank_q;

`ifdef SYSBUF_STATUS_EN
  localparam int FW = $clog2(NUM_BANKS + 1);

  logic [NUM_BANKS-1:0] bank_busy;
  logic [NUM_BANKS-1:0] bank_live;
  logic                 err_drop_q;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_flags
    assign bank_busy[gi] = (state_q[gi] == B_FULL) || (state_q[gi] == B_DRAINING);
    assign bank_live[gi] = (state_q[gi] != B_EMPTY);
  end

  always_comb begin
    full_banks = '0;
    for (int i = 0; i < NUM_BANKS; i++) full_banks = full_banks + FW'(bank_busy[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_drop_q <= 1'b0;
    end else if (flush && ((|bank_live) || rd_valid_q)) begin
      err_drop_q <= 1'b1;
    end
  end

  assign err_drop = err_drop_q;
`endif

endmodule

// File: tb/tb_systolic_pingpong_buffer.sv
// Self-checking bench for systolic_pingpong_buffer: a table of fills, directed corner sequences, and random traffic.
// Every cycle the outputs are scored against a queue-based model of banks and rows.
module tb_systolic_pingpong_buffer;
  localparam int DW    = 32;
  localparam int N     = 32;
  localparam int DEPTH = 543;
  localparam int AW    = 10;
  localparam int NB    = 2;
  localparam int W     = DW * N;
  localparam int BW    = $clog2(NB);

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  systolic_pingpong_buffer_if #(.W(W), .BW(BW)) bus ();

`ifdef SYSBUF_STATUS_EN
  logic [$clog2(NB+1)-1:0] full_banks;
  logic                    err_drop;
`endif

  systolic_pingpong_buffer #(
    .DATAWIDTH_output(DW), .N_SIZE(N), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_BANKS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
`ifdef SYSBUF_STATUS_EN
    , .full_banks(full_banks), .err_drop(err_drop)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    bit           last;
    int           bank;
  } exp_row_t;

  typedef struct {
    int n_rows;
    bit use_last;
    int stall_pct;
    int exp_rows;
    int exp_last_idx;
    int exp_bank;
  } fill_vec_t;

  int errors = 0;
  int n_checks = 0;

  // Reference model: rows of closed banks in read order, rows of the open fill, number of closed-but-unfreed banks.
  exp_row_t     expq[$];
  logic [W-1:0] cur_rows[$];
  int           closed_cnt = 0;
  int           model_wb = 0;
  bit           err_exp = 0;
  bit           stalled_prev = 0;
  int           idle = 0;
  logic [W-1:0] held_data;
  logic         held_last;
  logic [BW-1:0] held_bank;

  bit s_wr_beat, s_rd_beat, s_rd_last;
  int s_rd_bank;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_row(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (low 128 bits) at %0t", nm, act[127:0], exp[127:0], $time);
    end
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic model_clear();
    expq.delete();
    cur_rows.delete();
    closed_cnt   = 0;
    model_wb     = 0;
    stalled_prev = 0;
    idle         = 0;
  endtask

  // Called at posedge+1 with inputs already set; samples, scores, updates the model, returns at the next posedge+1.
  task automatic step();
    exp_row_t e;
    exp_row_t er;
    #1;
    s_wr_beat = 0; s_rd_beat = 0; s_rd_last = 0; s_rd_bank = -1;
    chk("wr_ready", bus.wr_ready, (closed_cnt < NB && !flush) ? 1 : 0);
`ifdef SYSBUF_STATUS_EN
    chk("full_banks", full_banks, closed_cnt);
    chk("err_drop", err_drop, err_exp);
`endif
    if (expq.size() == 0) begin
      chk("rd_valid_empty", bus.rd_valid, 0);
      idle = 0;
    end else if (!bus.rd_valid) begin
      idle++;
      chk("rd_latency_ok", (idle <= 8) ? 1 : 0, 1);
    end else begin
      idle = 0;
    end
    if (stalled_prev) begin
      chk("hold_valid", bus.rd_valid, 1);
      chk_row("hold_data", bus.rd_data, held_data);
      chk("hold_last", bus.rd_last, held_last);
      chk("hold_bank", bus.rd_bank, held_bank);
    end
    if (flush) begin
      if (closed_cnt > 0 || cur_rows.size() > 0 || bus.rd_valid) err_exp = 1;
      model_clear();
    end else begin
      if (bus.wr_valid && bus.wr_ready) begin
        s_wr_beat = 1;
        cur_rows.push_back(bus.wr_data);
        if (bus.wr_last || cur_rows.size() == DEPTH) begin
          foreach (cur_rows[i]) begin
            er.data = cur_rows[i];
            er.last = (i == cur_rows.size() - 1);
            er.bank = model_wb;
            expq.push_back(er);
          end
          cur_rows.delete();
          closed_cnt++;
          model_wb = (model_wb + 1) % NB;
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        s_rd_beat = 1;
        s_rd_last = bus.rd_last;
        s_rd_bank = int'(bus.rd_bank);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk_row("rd_data", bus.rd_data, e.data);
          chk("rd_last", bus.rd_last, e.last);
          chk("rd_bank", bus.rd_bank, e.bank);
          if (e.last) closed_cnt--;
        end
      end
      stalled_prev = bus.rd_valid && !bus.rd_ready;
      held_data = bus.rd_data;
      held_last = bus.rd_last;
      held_bank = bus.rd_bank;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input int n, input bit use_last, input int pct,
                          output int rows, output int last_idx, output int last_cnt, output int bank);
    int wrote;
    int cyc;
    wrote = 0; cyc = 0; rows = 0; last_idx = -1; last_cnt = 0; bank = -1;
    while ((wrote < n || rows < n) && cyc < n * 4 + 200) begin
      bus.wr_valid = (wrote < n);
      bus.wr_last  = use_last && (wrote == n - 1);
      bus.wr_data  = rand_row();
      bus.rd_ready = ($urandom_range(99) >= pct);
      step();
      if (s_wr_beat) wrote++;
      if (s_rd_beat) begin
        if (s_rd_last) begin
          last_cnt++;
          if (last_idx < 0) last_idx = rows;
        end
        if (bank < 0) bank = s_rd_bank;
        rows++;
      end
      cyc++;
    end
    bus.wr_valid = 0; bus.wr_last = 0; bus.rd_ready = 0;
  endtask

  fill_vec_t vecs[6];
  logic [W-1:0] zero_row;

  initial begin
    int rows, last_idx, last_cnt, bank, beats, reads, cyc;

    vecs[0] = '{n_rows: 4,     use_last: 1, stall_pct: 0,  exp_rows: 4,     exp_last_idx: 3,         exp_bank: 0};
    vecs[1] = '{n_rows: 3,     use_last: 1, stall_pct: 50, exp_rows: 3,     exp_last_idx: 2,         exp_bank: 1};
    vecs[2] = '{n_rows: 8,     use_last: 1, stall_pct: 50, exp_rows: 8,     exp_last_idx: 7,         exp_bank: 0};
    vecs[3] = '{n_rows: DEPTH, use_last: 0, stall_pct: 0,  exp_rows: DEPTH, exp_last_idx: DEPTH - 1, exp_bank: 1};
    vecs[4] = '{n_rows: 1,     use_last: 1, stall_pct: 30, exp_rows: 1,     exp_last_idx: 0,         exp_bank: 0};
    vecs[5] = '{n_rows: 5,     use_last: 1, stall_pct: 70, exp_rows: 5,     exp_last_idx: 4,         exp_bank: 1};
    zero_row = '0;

    rst_n = 0; flush = 0;
    bus.wr_valid = 0; bus.wr_last = 0; bus.wr_data = '0; bus.rd_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk_row("rst_rd_data", bus.rd_data, zero_row);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_rd_bank", bus.rd_bank, 0);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_wr_ready", bus.wr_ready, 1);

    // Table of fills: row count, closing row position, source bank.
    for (int v = 0; v < 6; v++) begin
      run_fill(vecs[v].n_rows, vecs[v].use_last, vecs[v].stall_pct, rows, last_idx, last_cnt, bank);
      chk($sformatf("vec%0d_rows", v), rows, vecs[v].exp_rows);
      chk($sformatf("vec%0d_last_idx", v), last_idx, vecs[v].exp_last_idx);
      chk($sformatf("vec%0d_last_cnt", v), last_cnt, 1);
      chk($sformatf("vec%0d_bank", v), bank, vecs[v].exp_bank);
      if (v == 0) chk("t1_rd_idle", bus.rd_valid, 0);
    end

    // Two banks of 3 rows with the consumer stalled: writer blocks until bank 0 drains.
    beats = 0; cyc = 0;
    bus.rd_ready = 0;
    while (beats < 6 && cyc < 50) begin
      bus.wr_valid = 1;
      bus.wr_data  = rand_row();
      bus.wr_last  = (beats == 2 || beats == 5);
      step();
      if (s_wr_beat) beats++;
      cyc++;
    end
    bus.wr_valid = 0; bus.wr_last = 0;
    chk("t2_beats", beats, 6);
    chk("t2_wr_stalled", bus.wr_ready, 0);
    reads = 0; cyc = 0;
    bus.rd_ready = 1;
    while (reads < 3 && cyc < 50) begin
      step();
      if (s_rd_beat) reads++;
      cyc++;
    end
    chk("t2_bank0_rows", reads, 3);
    chk("t2_wr_resume", bus.wr_ready, 1);
    cyc = 0;
    while (reads < 6 && cyc < 50) begin
      step();
      if (s_rd_beat) reads++;
      cyc++;
    end
    chk("t2_all_rows", reads, 6);
    bus.rd_ready = 0;

    // Random traffic with occasional flushes.
    for (int c = 0; c < 800; c++) begin
      bus.wr_valid = ($urandom_range(99) < 70);
      bus.wr_last  = ($urandom_range(99) < 12);
      bus.wr_data  = rand_row();
      bus.rd_ready = ($urandom_range(99) < 60);
      flush        = ($urandom_range(999) < 5);
      step();
    end
    flush = 0;
    bus.rd_ready = 1;
    cyc = 0;
    while (cur_rows.size() > 0 && cyc < 100) begin
      bus.wr_valid = 1; bus.wr_last = 1; bus.wr_data = rand_row();
      step();
      cyc++;
    end
    bus.wr_valid = 0; bus.wr_last = 0;
    cyc = 0;
    while (expq.size() > 0 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("rand_drained", expq.size(), 0);
    step();
    bus.rd_ready = 0;

    // Flush with one bank FULL and the next one mid-fill.
    beats = 0; cyc = 0;
    while (beats < 3 && cyc < 50) begin
      bus.wr_valid = 1;
      bus.wr_data  = rand_row();
      bus.wr_last  = (beats == 1);
      step();
      if (s_wr_beat) beats++;
      cyc++;
    end
    bus.wr_valid = 0; bus.wr_last = 0;
    repeat (3) step();
    chk("t5_pre_valid", bus.rd_valid, 1);
    flush = 1;
    step();
    flush = 0;
    #1;
    chk("t5_rd_valid", bus.rd_valid, 0);
    chk("t5_wr_ready", bus.wr_ready, 1);
`ifdef SYSBUF_STATUS_EN
    chk("t5_err_drop", err_drop, 1);
`endif
    run_fill(2, 1, 0, rows, last_idx, last_cnt, bank);
    chk("t5_rows", rows, 2);
    chk("t5_bank", bank, 0);

    // Asynchronous reset in the middle of a drain.
    beats = 0; reads = 0; cyc = 0;
    while (reads < 2 && cyc < 50) begin
      bus.wr_valid = (beats < 4);
      bus.wr_data  = rand_row();
      bus.wr_last  = (beats == 3);
      bus.rd_ready = 1;
      step();
      if (s_wr_beat) beats++;
      if (s_rd_beat) reads++;
      cyc++;
    end
    bus.wr_valid = 0; bus.wr_last = 0;
    chk("t6_pre_valid", bus.rd_valid, 1);
    bus.rd_ready = 0;
    rst_n = 0;
    #1;
    chk("t6_rd_valid_async", bus.rd_valid, 0);
    chk("t6_rd_last_async", bus.rd_last, 0);
    model_clear();
    err_exp = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    chk("t6_rd_valid", bus.rd_valid, 0);
    chk_row("t6_rd_data", bus.rd_data, zero_row);
    chk("t6_rd_last", bus.rd_last, 0);
    chk("t6_rd_bank", bus.rd_bank, 0);
    chk("t6_wr_ready", bus.wr_ready, 1);
`ifdef SYSBUF_STATUS_EN
    chk("t6_err_drop", err_drop, 0);
`endif
    run_fill(3, 1, 20, rows, last_idx, last_cnt, bank);
    chk("t6_rows", rows, 3);
    chk("t6_last_idx", last_idx, 2);
    chk("t6_bank", bank, 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
